// File: rtl/address_generation_unit.sv
// Effective-address generator for the 6502 core: resolves the eight data addressing
// modes, fetches zero-page pointers for (zp,X)/(zp),Y and flags page crossings.
module address_generation_unit #(
  parameter logic [7:0] ZP_PAGE = 8'h00
) (
  input  logic       FSM_Signal,
  input  logic       reset_AGU,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic [7:0] OPER_LO,
  input  logic [7:0] OPER_HI,
  input  logic [7:0] X_REG,
  input  logic [7:0] Y_REG,
  input  logic [7:0] DATA_IN,
  input  logic       data_valid,
  output logic [7:0] OUT_HIGH,
  output logic [7:0] OUT_LOW,
  output logic       load_MARH,
  output logic       load_MARL,
  output logic       rd_req,
  output logic       busy,
  output logic       done,
  output logic       page_cross
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_PTR_LO, S_WAIT_LO, S_PTR_HI, S_WAIT_HI, S_FIX, S_LOAD
  } state_t;

  localparam logic [2:0] M_ZP    = 3'd0;
  localparam logic [2:0] M_ZP_X  = 3'd1;
  localparam logic [2:0] M_ZP_Y  = 3'd2;
  localparam logic [2:0] M_ABS   = 3'd3;
  localparam logic [2:0] M_ABS_X = 3'd4;
  localparam logic [2:0] M_ABS_Y = 3'd5;
  localparam logic [2:0] M_IND_X = 3'd6;
  localparam logic [2:0] M_IND_Y = 3'd7;

  state_t      state_q;
  logic [2:0]  mode_q;
  logic [7:0]  lo_q, hi_q, x_q, y_q, ptr_q, ptr_lo_byte_q;
  logic [15:0] ea_q;

  logic [7:0]  idx_s;
  logic [8:0]  lo_sum_s;
  logic [15:0] calc_ea_s;
  logic        calc_cross_s;
  logic [8:0]  ind_sum_s;
  logic [15:0] ind_ea_s;
  logic        ind_cross_s;

  // Direct-mode address arithmetic, working on the operands latched at start.
  always_comb begin
    idx_s        = ((mode_q == M_ZP_Y) || (mode_q == M_ABS_Y)) ? y_q : x_q;
    lo_sum_s     = {1'b0, lo_q} + {1'b0, idx_s};
    calc_cross_s = 1'b0;
    case (mode_q)
      M_ZP:             calc_ea_s = {ZP_PAGE, lo_q};
      M_ZP_X, M_ZP_Y:   calc_ea_s = {ZP_PAGE, lo_sum_s[7:0]};
      M_ABS:            calc_ea_s = {hi_q, lo_q};
      M_ABS_X, M_ABS_Y: begin
        calc_ea_s    = {hi_q + {7'd0, lo_sum_s[8]}, lo_sum_s[7:0]};
        calc_cross_s = lo_sum_s[8];
      end
      default:          calc_ea_s = {hi_q, lo_q};
    endcase
  end

  // Indirect EA is formed in WAIT_HI directly from the high pointer byte on DATA_IN.
  always_comb begin
    ind_sum_s = {1'b0, ptr_lo_byte_q} + {1'b0, y_q};
    if (mode_q == M_IND_Y) begin
      ind_ea_s    = {DATA_IN + {7'd0, ind_sum_s[8]}, ind_sum_s[7:0]};
      ind_cross_s = ind_sum_s[8];
    end else begin
      ind_ea_s    = {DATA_IN, ptr_lo_byte_q};
      ind_cross_s = 1'b0;
    end
  end

  // Sequencer: every output is registered alongside the state it belongs to.
  always_ff @(posedge FSM_Signal) begin
    if (reset_AGU) begin
      state_q       <= S_IDLE;
      mode_q        <= 3'd0;
      lo_q          <= 8'h00;
      hi_q          <= 8'h00;
      x_q           <= 8'h00;
      y_q           <= 8'h00;
      ptr_q         <= 8'h00;
      ptr_lo_byte_q <= 8'h00;
      ea_q          <= 16'h0000;
      OUT_HIGH      <= 8'h00;
      OUT_LOW       <= 8'h00;
      load_MARH     <= 1'b0;
      load_MARL     <= 1'b0;
      rd_req        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      page_cross    <= 1'b0;
    end else begin
      load_MARH <= 1'b0;
      load_MARL <= 1'b0;
      rd_req    <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            lo_q       <= OPER_LO;
            hi_q       <= OPER_HI;
            x_q        <= X_REG;
            y_q        <= Y_REG;
            page_cross <= 1'b0;
            busy       <= 1'b1;
            state_q    <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          if ((mode_q == M_IND_X) || (mode_q == M_IND_Y)) begin
            ptr_q     <= (mode_q == M_IND_X) ? lo_sum_s[7:0] : lo_q;
            OUT_HIGH  <= ZP_PAGE;
            OUT_LOW   <= (mode_q == M_IND_X) ? lo_sum_s[7:0] : lo_q;
            load_MARH <= 1'b1;
            load_MARL <= 1'b1;
            rd_req    <= 1'b1;
            state_q   <= S_PTR_LO;
          end else if (calc_cross_s) begin
            ea_q       <= calc_ea_s;
            page_cross <= 1'b1;
            state_q    <= S_FIX;
          end else begin
            {OUT_HIGH, OUT_LOW} <= calc_ea_s;
            load_MARH  <= 1'b1;
            load_MARL  <= 1'b1;
            done       <= 1'b1;
            page_cross <= 1'b0;
            state_q    <= S_LOAD;
          end
        end
        S_PTR_LO: state_q <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (data_valid) begin
            ptr_lo_byte_q <= DATA_IN;
            OUT_HIGH      <= ZP_PAGE;
            OUT_LOW       <= ptr_q + 8'd1;
            load_MARH     <= 1'b1;
            load_MARL     <= 1'b1;
            rd_req        <= 1'b1;
            state_q       <= S_PTR_HI;
          end else begin
            state_q <= S_WAIT_LO;
          end
        end
        S_PTR_HI: state_q <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (!data_valid) begin
            state_q <= S_WAIT_HI;
          end else if (ind_cross_s) begin
            ea_q       <= ind_ea_s;
            page_cross <= 1'b1;
            state_q    <= S_FIX;
          end else begin
            {OUT_HIGH, OUT_LOW} <= ind_ea_s;
            load_MARH  <= 1'b1;
            load_MARL  <= 1'b1;
            done       <= 1'b1;
            page_cross <= 1'b0;
            state_q    <= S_LOAD;
          end
        end
        S_FIX: begin
          {OUT_HIGH, OUT_LOW} <= ea_q;
          load_MARH <= 1'b1;
          load_MARL <= 1'b1;
          done      <= 1'b1;
          state_q   <= S_LOAD;
        end
        S_LOAD: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_address_generation_unit.sv
// Bench for address_generation_unit: table of addressing-mode vectors checked through
// a scoreboard, plus hand-written sequences for reset abort and ignored inputs.
module tb_address_generation_unit;

  logic       clk = 1'b0;
  logic       reset_AGU, start, data_valid;
  logic [2:0] mode;
  logic [7:0] OPER_LO, OPER_HI, X_REG, Y_REG, DATA_IN;
  logic [7:0] OUT_HIGH, OUT_LOW;
  logic       load_MARH, load_MARL, rd_req, busy, done, page_cross;

  address_generation_unit #(.ZP_PAGE(8'h00)) dut (
    .FSM_Signal(clk), .reset_AGU(reset_AGU), .start(start), .mode(mode),
    .OPER_LO(OPER_LO), .OPER_HI(OPER_HI), .X_REG(X_REG), .Y_REG(Y_REG),
    .DATA_IN(DATA_IN), .data_valid(data_valid),
    .OUT_HIGH(OUT_HIGH), .OUT_LOW(OUT_LOW), .load_MARH(load_MARH),
    .load_MARL(load_MARL), .rd_req(rd_req), .busy(busy), .done(done),
    .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  lo, hi, x, y;
    int          dly;
    logic [15:0] ea;
    logic        pc;
    int          lat;
    int          nrd;
    logic [15:0] rd0, rd1;
  } vec_t;

  vec_t        vecs [12];
  vec_t        sb_q [$];
  logic [15:0] rd_seen_q [$];
  logic [7:0]  mem [256];
  logic [15:0] last_ea;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Follows one operation from the CALC cycle to done, acting as the memory responder.
  task automatic track(input int dly, input bit poke);
    int          lat = 1;
    bit          seen = 1'b0;
    bit          pend = 1'b0;
    bit          busy_bad = 1'b0;
    int          cnt = 0;
    int          nload = 0;
    logic [15:0] raddr = 16'h0000;
    vec_t        e;
    rd_seen_q.delete();
    seen = 1'b0;
    while (!seen && lat < 80) begin
      if (lat == 1) chk("pc_clear_on_start", {31'd0, page_cross}, 32'd0);
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (load_MARL) nload++;
      if (rd_req) begin
        raddr = {OUT_HIGH, OUT_LOW};
        rd_seen_q.push_back(raddr);
        pend = 1'b1;
        cnt = dly;
        data_valid = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          data_valid = 1'b1;
          DATA_IN = mem[raddr[7:0]];
          pend = 1'b0;
        end else begin
          cnt--;
          data_valid = 1'b0;
        end
      end else begin
        data_valid = 1'b0;
      end
      if (poke) begin
        start = (lat == 1) || (lat == 2);
        mode = 3'd0;
        OPER_LO = 8'h55;
      end
      if (done) begin
        seen = 1'b1;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("ea", {16'd0, OUT_HIGH, OUT_LOW}, {16'd0, e.ea});
          chk("page_cross", {31'd0, page_cross}, {31'd0, e.pc});
          chk("latency", lat, e.lat);
          chk("done_strobes", {29'd0, load_MARH, load_MARL, rd_req}, 32'd6);
          chk("load_count", nload, e.nrd + 1);
          chk("read_count", rd_seen_q.size(), e.nrd);
          if (e.nrd == 2 && rd_seen_q.size() == 2) begin
            chk("read_addr0", {16'd0, rd_seen_q[0]}, {16'd0, e.rd0});
            chk("read_addr1", {16'd0, rd_seen_q[1]}, {16'd0, e.rd1});
          end
          last_ea = e.ea;
        end
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    data_valid = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_during_op", {31'd0, busy_bad}, 32'd0);
    if (!seen) sb_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input bit poke);
    start = 1'b1;
    mode = v.mode;
    OPER_LO = v.lo;
    OPER_HI = v.hi;
    X_REG = v.x;
    Y_REG = v.y;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    track(v.dly, poke);
    @(negedge clk);
    chk("idle_after_done", {27'd0, busy, done, load_MARH, load_MARL, rd_req}, 32'd0);
    chk("out_hold", {16'd0, OUT_HIGH, OUT_LOW}, {16'd0, last_ea});
  endtask

  initial begin
    int   nrd;
    bit   pend;
    vec_t v;
    reset_AGU = 1'b1; start = 1'b0; data_valid = 1'b0; mode = 3'd0;
    OPER_LO = 8'h00; OPER_HI = 8'h00; X_REG = 8'h00; Y_REG = 8'h00; DATA_IN = 8'h00;
    last_ea = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
    mem[8'h80] = 8'hFF; mem[8'h81] = 8'h20;
    mem[8'h10] = 8'h00; mem[8'h11] = 8'h30;

    //           mode  lo     hi     x      y      dly ea        pc    lat nrd rd0        rd1
    vecs[0]  = '{3'd0, 8'h45, 8'h00, 8'h00, 8'h00, 0, 16'h0045, 1'b0, 2,  0, 16'h0000, 16'h0000};
    vecs[1]  = '{3'd1, 8'hF0, 8'h00, 8'h20, 8'h00, 0, 16'h0010, 1'b0, 2,  0, 16'h0000, 16'h0000};
    vecs[2]  = '{3'd2, 8'h80, 8'h00, 8'h00, 8'h05, 0, 16'h0085, 1'b0, 2,  0, 16'h0000, 16'h0000};
    vecs[3]  = '{3'd3, 8'h34, 8'h12, 8'h00, 8'h00, 0, 16'h1234, 1'b0, 2,  0, 16'h0000, 16'h0000};
    vecs[4]  = '{3'd4, 8'hF0, 8'h12, 8'h20, 8'h00, 0, 16'h1310, 1'b1, 3,  0, 16'h0000, 16'h0000};
    vecs[5]  = '{3'd4, 8'h10, 8'h12, 8'h20, 8'h00, 0, 16'h1230, 1'b0, 2,  0, 16'h0000, 16'h0000};
    vecs[6]  = '{3'd5, 8'hFF, 8'hFF, 8'h00, 8'h01, 0, 16'h0000, 1'b1, 3,  0, 16'h0000, 16'h0000};
    vecs[7]  = '{3'd5, 8'h00, 8'h40, 8'h00, 8'hFF, 0, 16'h40FF, 1'b0, 2,  0, 16'h0000, 16'h0000};
    vecs[8]  = '{3'd6, 8'hFE, 8'h00, 8'h01, 8'h00, 0, 16'h1234, 1'b0, 6,  2, 16'h00FF, 16'h0000};
    vecs[9]  = '{3'd7, 8'h80, 8'h00, 8'h00, 8'h01, 2, 16'h2100, 1'b1, 11, 2, 16'h0080, 16'h0081};
    vecs[10] = '{3'd7, 8'h10, 8'h00, 8'h00, 8'h05, 0, 16'h3005, 1'b0, 6,  2, 16'h0010, 16'h0011};
    vecs[11] = '{3'd6, 8'h20, 8'h00, 8'hF0, 8'h00, 0, 16'h3000, 1'b0, 6,  2, 16'h0010, 16'h0011};

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {16'd0, OUT_HIGH, OUT_LOW} | {26'd0, load_MARH, load_MARL, rd_req, busy, done, page_cross},
        32'd0);
    reset_AGU = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

    // data_valid while idle must not disturb anything
    data_valid = 1'b1;
    DATA_IN = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      chk("dv_in_idle", {27'd0, busy, done, load_MARH, load_MARL, rd_req}, 32'd0);
      chk("dv_in_idle_out", {16'd0, OUT_HIGH, OUT_LOW}, {16'd0, last_ea});
    end
    data_valid = 1'b0;

    // start re-pulsed with other operands while busy
    run_vec(vecs[4], 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart", {30'd0, busy, done}, 32'd0);
    end

    // reset while waiting for the high pointer byte
    start = 1'b1; mode = 3'd6; OPER_LO = 8'hFE; X_REG = 8'h01;
    @(negedge clk);
    start = 1'b0;
    nrd = 0;
    pend = 1'b0;
    for (int c = 0; c < 30 && nrd < 2; c++) begin
      @(negedge clk);
      if (rd_req) begin
        nrd++;
        data_valid = 1'b0;
        pend = (nrd == 1);
      end else if (pend) begin
        data_valid = 1'b1;
        DATA_IN = mem[8'hFF];
        pend = 1'b0;
      end else begin
        data_valid = 1'b0;
      end
    end
    chk("reach_ptr_hi", nrd, 2);
    @(negedge clk);
    chk("in_wait_hi", {31'd0, busy}, 32'd1);
    reset_AGU = 1'b1;
    @(negedge clk);
    reset_AGU = 1'b0;
    chk("abort_outputs",
        {16'd0, OUT_HIGH, OUT_LOW} | {26'd0, load_MARH, load_MARL, rd_req, busy, done, page_cross},
        32'd0);
    last_ea = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", {27'd0, busy, done, load_MARH, load_MARL, rd_req}, 32'd0);
    end
    v = '{3'd0, 8'h77, 8'h00, 8'h00, 8'h00, 0, 16'h0077, 1'b0, 2, 0, 16'h0000, 16'h0000};
    run_vec(v, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
